// File: rtl/molecule_beat_dispatcher_pkg.sv
// Shared constants and types for the molecule beat dispatcher.
// Covers the molecule width, beat-count helpers and the serializer state encoding.
package molecule_beat_dispatcher_pkg;

  localparam int unsigned MOLECULE_W     = 256;
  localparam int unsigned DEFAULT_BEAT_W = 64;
  localparam int unsigned NUM_BEATS      = MOLECULE_W / DEFAULT_BEAT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  // Number of beats a molecule occupies at a given beat width.
  function automatic int unsigned beat_count(input int unsigned beat_w);
    return MOLECULE_W / beat_w;
  endfunction

  // Beat index width; a single-beat molecule still gets a one-bit index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/molecule_beat_dispatcher_fifo.sv
// Circular molecule queue with occupancy count.
// A push into a full queue is accepted only when a pop happens in the same cycle.
module molecule_fifo
  import molecule_beat_dispatcher_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = MOLECULE_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic                     drop_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             accept_c;
  logic             do_pop_c;

  assign full_c   = (count == CNT_W'(DEPTH));
  assign empty_c  = (count == '0);
  assign do_pop_c = pop && !empty_c;
  assign accept_c = push && (!full_c || do_pop_c);
  assign drop_c   = push && full_c && !do_pop_c;
  assign head_c   = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({accept_c, do_pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/molecule_beat_dispatcher.sv
// Queues 256-bit molecules and serializes each into BEAT_W-wide beats, LSB beat first,
// over a valid/ready link, chaining molecules back-to-back when the queue is non-empty.
module molecule_beat_dispatcher
  import molecule_beat_dispatcher_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned BEAT_W = DEFAULT_BEAT_W
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [MOLECULE_W-1:0]                      molecule_in,
  input  logic                                       molecule_ready,
  output logic [BEAT_W-1:0]                          beat_data,
  output logic                                       beat_valid,
  input  logic                                       beat_ready,
  output logic                                       beat_last,
  output logic [idx_width(beat_count(BEAT_W))-1:0]   beat_index,
  output logic [$clog2(DEPTH):0]                     queue_count,
  output logic [7:0]                                 overflow_count,
  output logic                                       busy
);

  localparam int unsigned BEATS = beat_count(BEAT_W);
  localparam int unsigned IDX_W = idx_width(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  state_t                state;
  state_t                next_state;
  logic [MOLECULE_W-1:0] shreg;
  logic                  pop_c;
  logic                  load_c;
  logic                  shift_c;
  logic                  xfer_c;
  logic                  push_c;
  logic [MOLECULE_W-1:0] head_c;
  logic                  full_c;
  logic                  empty_c;
  logic                  drop_c;

  assign push_c = molecule_ready && !reset;
  assign xfer_c = beat_valid && beat_ready;

  molecule_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (MOLECULE_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .push_data (molecule_in),
    .pop       (pop_c),
    .head_c    (head_c),
    .full_c    (full_c),
    .empty_c   (empty_c),
    .drop_c    (drop_c),
    .count     (queue_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Serializer sequencing: load pops the head, send shifts on each accepted beat.
  always_comb begin
    next_state = state;
    pop_c      = 1'b0;
    load_c     = 1'b0;
    shift_c    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty_c) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        pop_c      = 1'b1;
        load_c     = 1'b1;
        next_state = SEND;
      end
      SEND: begin
        if (xfer_c) begin
          if (beat_last) begin
            if (!empty_c) begin
              pop_c  = 1'b1;
              load_c = 1'b1;
            end else begin
              next_state = IDLE;
            end
          end else begin
            shift_c = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= '0;
      beat_index <= '0;
      beat_last  <= 1'b0;
      beat_valid <= 1'b0;
    end else begin
      beat_valid <= (next_state == SEND);
      if (load_c) begin
        shreg      <= head_c;
        beat_index <= '0;
        beat_last  <= (BEATS == 1);
      end else if (shift_c) begin
        shreg      <= shreg >> BEAT_W;
        beat_index <= beat_index + IDX_W'(1);
        beat_last  <= ((beat_index + IDX_W'(1)) == LAST_IDX);
      end
    end
  end

  // Dropped pushes are counted and the count sticks at its maximum.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_count <= '0;
    end else if (drop_c && (overflow_count != 8'hFF)) begin
      overflow_count <= overflow_count + 8'd1;
    end
  end

  assign beat_data = shreg[BEAT_W-1:0];
  assign busy      = (state != IDLE) || (queue_count != '0);

endmodule

// File: tb/tb_molecule_beat_dispatcher.sv
// Scoreboard bench for molecule_beat_dispatcher: directed pushes queue expected beats,
// a negedge monitor compares every accepted beat against the queue head.
module tb_molecule_beat_dispatcher;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned BEAT_W = 64;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  idx;
    logic        last;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] molecule_in;
  logic         molecule_ready;
  logic [63:0]  beat_data;
  logic         beat_valid;
  logic         beat_ready;
  logic         beat_last;
  logic [1:0]   beat_index;
  logic [2:0]   queue_count;
  logic [7:0]   overflow_count;
  logic         busy;

  beat_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  molecule_beat_dispatcher #(
    .DEPTH  (DEPTH),
    .BEAT_W (BEAT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .molecule_in    (molecule_in),
    .molecule_ready (molecule_ready),
    .beat_data      (beat_data),
    .beat_valid     (beat_valid),
    .beat_ready     (beat_ready),
    .beat_last      (beat_last),
    .beat_index     (beat_index),
    .queue_count    (queue_count),
    .overflow_count (overflow_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] mol(input logic [63:0] base);
    return {base + 64'd3, base + 64'd2, base + 64'd1, base};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic expect_mol(input logic [63:0] base, input int nb);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.data = base + 64'(i);
      b.idx  = 2'(i);
      b.last = (i == 3);
      exp_q.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_mol(input logic [63:0] base);
    molecule_in    = mol(base);
    molecule_ready = 1'b1;
    tick();
    molecule_ready = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (beat_valid) return;
    end
    check(name, 256'(beat_valid), 256'(1));
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && !beat_valid) begin
        tick();
        return;
      end
    end
    check(name, 256'(busy), 256'(0));
    tick();
  endtask

  // Monitor: every accepted beat must match the head of the expected queue.
  always @(negedge clk) begin
    beat_t b;
    if (!reset && beat_valid && beat_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {beat_data, beat_index, beat_last}, 256'(0));
      end else begin
        b = exp_q.pop_front();
        check("beat", 256'({beat_data, beat_index, beat_last}), 256'({b.data, b.idx, b.last}));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    molecule_in    = '0;
    molecule_ready = 1'b0;
    beat_ready     = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_valid", 256'(beat_valid), 256'(0));
    check("rst_last", 256'(beat_last), 256'(0));
    check("rst_index", 256'(beat_index), 256'(0));
    check("rst_data", 256'(beat_data), 256'(0));
    check("rst_qc", 256'(queue_count), 256'(0));
    check("rst_ovf", 256'(overflow_count), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    tick();

    // Single molecule, latency and beat order
    expect_mol(64'h1, 4);
    push_mol(64'h1);
    @(negedge clk);
    check("lat_n_valid", 256'(beat_valid), 256'(0));
    check("lat_n_qc", 256'(queue_count), 256'(1));
    check("lat_n_busy", 256'(busy), 256'(1));
    tick();
    @(negedge clk);
    check("lat_load_valid", 256'(beat_valid), 256'(0));
    check("lat_load_qc", 256'(queue_count), 256'(1));
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("single_valid", 256'(beat_valid), 256'(1));
      check("single_index", 256'(beat_index), 256'(k));
      check("single_last", 256'(beat_last), 256'(k == 3));
      if (k == 0) check("single_qc", 256'(queue_count), 256'(0));
      tick();
    end
    @(negedge clk);
    check("single_idle_valid", 256'(beat_valid), 256'(0));
    tick();

    // Backpressure on beat 1
    beat_ready = 1'b0;
    expect_mol(64'h100, 4);
    push_mol(64'h100);
    wait_valid("bp_wait_valid");
    for (int k = 0; k < 5; k++) begin
      check("bp_data", 256'(beat_data), 256'(64'h100));
      check("bp_index", 256'(beat_index), 256'(0));
      check("bp_valid", 256'(beat_valid), 256'(1));
      tick();
      @(negedge clk);
    end
    tick();
    beat_ready = 1'b1;
    wait_idle("bp_drain");

    // Overflow: six pushes while stalled, sixth dropped
    beat_ready = 1'b0;
    for (int i = 0; i < 5; i++) expect_mol(64'h200 + 64'(i) * 64'h100, 4);
    for (int i = 0; i < 6; i++) begin
      molecule_in    = mol(64'h200 + 64'(i) * 64'h100);
      molecule_ready = 1'b1;
      tick();
    end
    molecule_ready = 1'b0;
    @(negedge clk);
    check("ovf_qc", 256'(queue_count), 256'(4));
    check("ovf_count", 256'(overflow_count), 256'(1));
    check("ovf_valid", 256'(beat_valid), 256'(1));
    tick();
    beat_ready = 1'b1;
    wait_idle("ovf_drain");
    check("ovf_count_after", 256'(overflow_count), 256'(1));

    // Back-to-back: 12 beats without a bubble
    beat_ready = 1'b0;
    for (int i = 0; i < 3; i++) expect_mol(64'h1000 + 64'(i) * 64'h100, 4);
    for (int i = 0; i < 3; i++) push_mol(64'h1000 + 64'(i) * 64'h100);
    wait_valid("b2b_wait_valid");
    check("b2b_qc", 256'(queue_count), 256'(2));
    tick();
    beat_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("b2b_valid", 256'(beat_valid), 256'(1));
      check("b2b_last", 256'(beat_last), 256'((k % 4) == 0));
      tick();
    end
    @(negedge clk);
    check("b2b_end_valid", 256'(beat_valid), 256'(0));
    tick();

    // Full queue, push on the cycle of the last-beat pop
    beat_ready = 1'b0;
    for (int i = 0; i < 6; i++) expect_mol(64'h2000 + 64'(i) * 64'h100, 4);
    for (int i = 0; i < 5; i++) push_mol(64'h2000 + 64'(i) * 64'h100);
    tick();
    @(negedge clk);
    check("full_qc", 256'(queue_count), 256'(4));
    check("full_valid", 256'(beat_valid), 256'(1));
    tick();
    beat_ready = 1'b1;
    repeat (3) tick();
    molecule_in    = mol(64'h2500);
    molecule_ready = 1'b1;
    @(negedge clk);
    check("full_last", 256'(beat_last), 256'(1));
    check("full_qc_before", 256'(queue_count), 256'(4));
    tick();
    molecule_ready = 1'b0;
    @(negedge clk);
    check("full_qc_after", 256'(queue_count), 256'(4));
    check("full_ovf_after", 256'(overflow_count), 256'(1));
    check("full_next_index", 256'(beat_index), 256'(0));
    check("full_next_valid", 256'(beat_valid), 256'(1));
    tick();
    wait_idle("full_drain");

    // Reset during beat 2 with two molecules queued
    beat_ready = 1'b0;
    expect_mol(64'h3000, 1);
    for (int i = 0; i < 3; i++) push_mol(64'h3000 + 64'(i) * 64'h100);
    wait_valid("rst_wait_valid");
    check("rstmid_qc", 256'(queue_count), 256'(2));
    tick();
    beat_ready = 1'b1;
    tick();
    reset          = 1'b1;
    molecule_in    = mol(64'h9900);
    molecule_ready = 1'b1;
    @(negedge clk);
    check("rstmid_index", 256'(beat_index), 256'(1));
    tick();
    reset          = 1'b0;
    molecule_ready = 1'b0;
    @(negedge clk);
    check("rstmid_valid", 256'(beat_valid), 256'(0));
    check("rstmid_qc_after", 256'(queue_count), 256'(0));
    check("rstmid_ovf", 256'(overflow_count), 256'(0));
    check("rstmid_busy", 256'(busy), 256'(0));
    check("rstmid_data", 256'(beat_data), 256'(0));
    tick();
    expect_mol(64'h4000, 4);
    push_mol(64'h4000);
    wait_idle("post_rst_drain");

    check("scoreboard_empty", 256'(exp_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
